// File: rtl/led_sched_pkg.sv
// Shared types for the LED bank scheduler: FSM state encoding and bank-index width helper.
package led_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_DRIVE,
        ST_BLANK
    } sched_state_e;

    function automatic int bank_bits(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/led_bank_scheduler_rr_pick.sv
// Combinational round-robin finder: first enabled bank strictly after start_idx, wrapping
// back to start_idx itself last so a lone enabled bank is re-granted.
module rr_pick
    import led_sched_pkg::*;
#(
    parameter int BANKS     = 2,
    parameter int BANK_BITS = bank_bits(BANKS)
) (
    input  logic [BANKS-1:0]     bank_en,
    input  logic [BANK_BITS-1:0] start_idx,
    output logic [BANK_BITS-1:0] next_idx,
    output logic                 valid
);

    // Walk offsets from farthest to nearest so the nearest enabled bank is written last.
    always_comb begin
        int cand;
        cand     = 0;
        next_idx = '0;
        valid    = 1'b0;
        for (int i = BANKS; i >= 1; i--) begin
            cand = (int'(start_idx) + i) % BANKS;
            if (bank_en[cand]) begin
                next_idx = BANK_BITS'(cand);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_bank_scheduler.sv
// Round-robin owner of a shared LED cathode bus with watchdog and dead-time blanking.
// Optional LED_BANK_SCHED_STATS_EN adds a saturating timeout_count output.
module led_bank_scheduler
    import led_sched_pkg::*;
#(
    parameter int BANKS        = 2,
    parameter int LEDS_N       = 10,
    parameter int LEDS_M       = 3,
    parameter int DEAD_BITS    = 8,
    parameter int TIMEOUT_BITS = 24,
    parameter int BANK_BITS    = bank_bits(BANKS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [BANKS-1:0]           bank_en,
    input  logic [DEAD_BITS-1:0]       dead_time,
    input  logic [TIMEOUT_BITS-1:0]    timeout,
    input  logic [BANKS-1:0]           done_tick,
    input  logic [BANKS*LEDS_N-1:0]    n_en_in,
    input  logic [BANKS*LEDS_M-1:0]    m_en_in,
    output logic [LEDS_N-1:0]          n_en,
    output logic [BANKS*LEDS_M-1:0]    m_en,
    output logic [BANKS-1:0]           active,
    output logic [BANK_BITS-1:0]       bank_idx,
    output logic                       switch_tick,
    output logic                       timeout_tick
`ifdef LED_BANK_SCHED_STATS_EN
    ,
    output logic [7:0]                 timeout_count
`endif
);

    sched_state_e                state_q, state_d;
    logic [BANK_BITS-1:0]        bank_idx_q, bank_idx_d;
    logic [TIMEOUT_BITS-1:0]     wd_q, wd_d;
    logic [DEAD_BITS-1:0]        dead_q, dead_d;
    logic [LEDS_N-1:0]           n_en_q, n_en_d;
    logic [BANKS*LEDS_M-1:0]     m_en_q, m_en_d;
    logic [BANKS-1:0]            active_q, active_d;
    logic                        switch_tick_q, switch_tick_d;
    logic                        timeout_tick_q, timeout_tick_d;

    logic [BANK_BITS-1:0]        pick_idx;
    logic                        pick_valid;
    logic                        any_bank;
    logic                        done_hit;
    logic                        wd_expired;
    logic                        wd_exit;

    rr_pick #(
        .BANKS     (BANKS),
        .BANK_BITS (BANK_BITS)
    ) u_rr_pick (
        .bank_en   (bank_en),
        .start_idx (bank_idx_q),
        .next_idx  (pick_idx),
        .valid     (pick_valid)
    );

    assign any_bank   = |bank_en;
    assign done_hit   = done_tick[bank_idx_q];
    assign wd_expired = (timeout != '0) && (wd_q >= timeout - TIMEOUT_BITS'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            bank_idx_q     <= BANK_BITS'(BANKS - 1);
            wd_q           <= '0;
            dead_q         <= '0;
            n_en_q         <= '0;
            m_en_q         <= '0;
            active_q       <= '0;
            switch_tick_q  <= 1'b0;
            timeout_tick_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bank_idx_q     <= bank_idx_d;
            wd_q           <= wd_d;
            dead_q         <= dead_d;
            n_en_q         <= n_en_d;
            m_en_q         <= m_en_d;
            active_q       <= active_d;
            switch_tick_q  <= switch_tick_d;
            timeout_tick_q <= timeout_tick_d;
        end
    end

    // A done pulse coinciding with watchdog expiry is treated as a normal end of scan.
    always_comb begin
        state_d    = state_q;
        bank_idx_d = bank_idx_q;
        wd_d       = wd_q;
        dead_d     = dead_q;
        wd_exit    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en && any_bank) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (en && pick_valid) begin
                    bank_idx_d = pick_idx;
                    wd_d       = '0;
                    state_d    = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                wd_d = wd_q + TIMEOUT_BITS'(1);
                if (done_hit || wd_expired || !bank_en[bank_idx_q] || !en) begin
                    wd_exit = wd_expired && !done_hit;
                    dead_d  = dead_time;
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (dead_q == '0) begin
                    state_d = (en && any_bank) ? ST_SELECT : ST_IDLE;
                end else begin
                    dead_d = dead_q - DEAD_BITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state they describe.
    always_comb begin
        n_en_d         = '0;
        m_en_d         = '0;
        active_d       = '0;
        switch_tick_d  = (state_q == ST_SELECT) && (state_d == ST_DRIVE);
        timeout_tick_d = wd_exit;
        if (state_d == ST_DRIVE) begin
            n_en_d                              = n_en_in[bank_idx_d*LEDS_N +: LEDS_N];
            m_en_d[bank_idx_d*LEDS_M +: LEDS_M] = m_en_in[bank_idx_d*LEDS_M +: LEDS_M];
            active_d[bank_idx_d]                = 1'b1;
        end
    end

    assign n_en         = n_en_q;
    assign m_en         = m_en_q;
    assign active       = active_q;
    assign bank_idx     = bank_idx_q;
    assign switch_tick  = switch_tick_q;
    assign timeout_tick = timeout_tick_q;

`ifdef LED_BANK_SCHED_STATS_EN
    logic [7:0] timeout_count_q, timeout_count_d;

    always_comb begin
        timeout_count_d = timeout_count_q;
        if (timeout_tick_d && (timeout_count_q != 8'hFF)) timeout_count_d = timeout_count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) timeout_count_q <= '0;
        else       timeout_count_q <= timeout_count_d;
    end

    assign timeout_count = timeout_count_q;
`endif

endmodule

// File: tb/tb_led_bank_scheduler.sv
// Self-checking bench for led_bank_scheduler: grant-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_led_bank_scheduler;

    localparam int BANKS        = 4;
    localparam int LEDS_N       = 10;
    localparam int LEDS_M       = 3;
    localparam int DEAD_BITS    = 8;
    localparam int TIMEOUT_BITS = 24;
    localparam int BANK_BITS    = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     en;
    logic [BANKS-1:0]         bank_en;
    logic [DEAD_BITS-1:0]     dead_time;
    logic [TIMEOUT_BITS-1:0]  timeout;
    logic [BANKS-1:0]         done_tick;
    logic [BANKS*LEDS_N-1:0]  n_en_in;
    logic [BANKS*LEDS_M-1:0]  m_en_in;
    logic [LEDS_N-1:0]        n_en;
    logic [BANKS*LEDS_M-1:0]  m_en;
    logic [BANKS-1:0]         active;
    logic [BANK_BITS-1:0]     bank_idx;
    logic                     switch_tick;
    logic                     timeout_tick;
`ifdef LED_BANK_SCHED_STATS_EN
    logic [7:0]               timeout_count;
`endif

    int checks   = 0;
    int failures = 0;

    led_bank_scheduler #(
        .BANKS        (BANKS),
        .LEDS_N       (LEDS_N),
        .LEDS_M       (LEDS_M),
        .DEAD_BITS    (DEAD_BITS),
        .TIMEOUT_BITS (TIMEOUT_BITS),
        .BANK_BITS    (BANK_BITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .bank_en      (bank_en),
        .dead_time    (dead_time),
        .timeout      (timeout),
        .done_tick    (done_tick),
        .n_en_in      (n_en_in),
        .m_en_in      (m_en_in),
        .n_en         (n_en),
        .m_en         (m_en),
        .active       (active),
        .bank_idx     (bank_idx),
        .switch_tick  (switch_tick),
        .timeout_tick (timeout_tick)
`ifdef LED_BANK_SCHED_STATS_EN
        ,
        .timeout_count (timeout_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant-level reference: which bank owns the bus, how long it has driven, blank time left.
    int                   m_grant = -1;
    int                   m_cycles = 0;
    int                   m_blank = 0;
    int                   m_last = BANKS - 1;
    int                   m_tcount = 0;
    bit                   m_sel = 1'b0;
    bit                   m_valid = 1'b0;
    logic [LEDS_N-1:0]    e_n = '0;
    logic [BANKS*LEDS_M-1:0] e_m = '0;
    logic [BANKS-1:0]     e_act = '0;
    bit                   e_sw = 1'b0;
    bit                   e_to = 1'b0;

    task automatic model_step();
        bit done_b, dog_b;
        int c;
        m_valid = 1'b1;
        if (reset) begin
            m_grant = -1; m_blank = 0; m_sel = 1'b0; m_last = BANKS - 1; m_tcount = 0;
            e_sw = 1'b0; e_to = 1'b0;
        end else begin
            e_sw = 1'b0;
            e_to = 1'b0;
            if (m_grant >= 0) begin
                m_cycles++;
                done_b = done_tick[m_grant];
                dog_b  = (timeout != 0) && (m_cycles >= int'(timeout));
                if (done_b || dog_b || !bank_en[m_grant] || !en) begin
                    e_to    = dog_b && !done_b;
                    m_grant = -1;
                    m_blank = int'(dead_time) + 1;
                end
            end else if (m_blank > 0) begin
                m_blank--;
                if (m_blank == 0) m_sel = en && (bank_en != 0);
            end else if (m_sel) begin
                m_sel = 1'b0;
                if (en) begin
                    for (int k = 1; k <= BANKS; k++) begin
                        c = (m_last + k) % BANKS;
                        if (m_grant < 0 && bank_en[c]) begin
                            m_grant  = c;
                            m_last   = c;
                            m_cycles = 0;
                            e_sw     = 1'b1;
                        end
                    end
                end
            end else begin
                m_sel = en && (bank_en != 0);
            end
            if (e_to && m_tcount < 255) m_tcount++;
        end
        e_n   = '0;
        e_m   = '0;
        e_act = '0;
        if (m_grant >= 0) begin
            e_n                            = n_en_in[m_grant*LEDS_N +: LEDS_N];
            e_m[m_grant*LEDS_M +: LEDS_M]  = m_en_in[m_grant*LEDS_M +: LEDS_M];
            e_act[m_grant]                 = 1'b1;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_valid) begin
            check_output("cmp_n_en",         64'(n_en),         64'(e_n));
            check_output("cmp_m_en",         64'(m_en),         64'(e_m));
            check_output("cmp_active",       64'(active),       64'(e_act));
            check_output("cmp_bank_idx",     64'(bank_idx),     64'(m_last));
            check_output("cmp_switch_tick",  64'(switch_tick),  64'(e_sw));
            check_output("cmp_timeout_tick", 64'(timeout_tick), 64'(e_to));
`ifdef LED_BANK_SCHED_STATS_EN
            check_output("cmp_timeout_count", 64'(timeout_count), 64'(m_tcount));
`endif
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_switch(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (switch_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        failures++;
        $display("[TB] FAIL global_time_limit actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit ok;
        int run, ticks, bad;
        int lens[$];
        int grants[$];
        int exp_seq[4];

        reset = 1'b1; en = 1'b0; bank_en = '0; done_tick = '0; dead_time = '0; timeout = '0;
        n_en_in = {10'h30F, 10'h0F0, 10'h2AA, 10'h155};
        m_en_in = {3'b110, 3'b111, 3'b011, 3'b101};
        repeat (3) @(negedge clk);
        check_output("reset_n_en",     64'(n_en),     64'(0));
        check_output("reset_active",   64'(active),   64'(0));
        check_output("reset_bank_idx", 64'(bank_idx), 64'(3));

        // Basic round-robin with done_tick.
        bank_en = 4'b0011; dead_time = 8'd3; timeout = '0; en = 1'b1; reset = 1'b0;
        wait_switch(20, ok);
        check_output("t1_first_switch", 64'(ok),       64'(1));
        check_output("t1_first_bank",   64'(bank_idx), 64'(0));
        repeat (19) @(negedge clk);
        check_output("t1_n_en_bank0",   64'(n_en),     64'(10'h155));
        check_output("t1_m_en_bank0",   64'(m_en),     64'(12'h005));
        done_tick = 4'b0001;
        @(negedge clk);
        done_tick = '0;
        for (int i = 0; i < 5; i++) begin
            check_output("t1_blank_n_en",   64'(n_en),        64'(0));
            check_output("t1_blank_switch", 64'(switch_tick), 64'(0));
            @(negedge clk);
        end
        check_output("t1_switch_tick",  64'(switch_tick), 64'(1));
        check_output("t1_bank_idx",     64'(bank_idx),    64'(1));
        check_output("t1_n_en_bank1",   64'(n_en),        64'(10'h2AA));
        check_output("t1_active",       64'(active),      64'(4'b0010));

        // Watchdog: every grant lasts exactly 50 cycles, banks alternate.
        timeout = 24'd50; dead_time = 8'd3; bank_en = 4'b0011;
        apply_reset();
        run = 0; ticks = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (switch_tick) grants.push_back(int'(bank_idx));
            if (timeout_tick) ticks++;
            if (active != 0) run++;
            else if (run > 0) begin
                lens.push_back(run);
                run = 0;
            end
            if (lens.size() == 3) break;
        end
        check_output("t2_grants_seen", 64'(lens.size()), 64'(3));
        foreach (lens[i]) check_output("t2_grant_len", 64'(lens[i]), 64'(50));
        check_output("t2_switch_count", 64'(grants.size()), 64'(3));
        exp_seq = '{0, 1, 0, 0};
        foreach (grants[i]) check_output("t2_bank_order", 64'(grants[i]), 64'(exp_seq[i]));
        check_output("t2_timeout_ticks", 64'(ticks), 64'(3));
`ifdef LED_BANK_SCHED_STATS_EN
        check_output("t2_timeout_count", 64'(timeout_count), 64'(3));
`endif

        // Skip disabled banks: only 1 and 3 may ever drive.
        timeout = '0; dead_time = 8'd1; bank_en = 4'b1010;
        apply_reset();
        grants.delete();
        run = 0; bad = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (m_en[2:0] != 0 || m_en[8:6] != 0) bad++;
            if (switch_tick) begin
                grants.push_back(int'(bank_idx));
                run = 0;
            end
            if (active != 0) begin
                run++;
                done_tick = (run == 5) ? active : '0;
            end else begin
                done_tick = '0;
            end
            if (grants.size() == 4) break;
        end
        done_tick = '0;
        check_output("t3_grants_seen", 64'(grants.size()), 64'(4));
        exp_seq = '{1, 3, 1, 3};
        foreach (grants[i]) check_output("t3_bank_order", 64'(grants[i]), 64'(exp_seq[i]));
        check_output("t3_disabled_m_en", 64'(bad), 64'(0));

        // Disable the driving bank mid-grant.
        dead_time = 8'd2; bank_en = 4'b0011;
        apply_reset();
        wait_switch(20, ok);
        check_output("t4_first_bank", 64'(bank_idx), 64'(0));
        repeat (3) @(negedge clk);
        n_en_in[9:0] = 10'h3C3;
        @(negedge clk);
        check_output("t4_latency_n_en", 64'(n_en), 64'(10'h3C3));
        bank_en = 4'b0010;
        @(negedge clk);
        check_output("t4_disable_n_en",   64'(n_en),   64'(0));
        check_output("t4_disable_active", 64'(active), 64'(0));
        wait_switch(10, ok);
        check_output("t4_regrant",      64'(ok),       64'(1));
        check_output("t4_regrant_bank", 64'(bank_idx), 64'(1));
        n_en_in[9:0] = 10'h155;
        bank_en = 4'b0011;

        // done_tick on the same cycle the watchdog expires counts as done.
        dead_time = 8'd2; timeout = 24'd10;
        apply_reset();
        wait_switch(20, ok);
        check_output("t5_first_bank", 64'(bank_idx), 64'(0));
        repeat (9) @(negedge clk);
        check_output("t5_still_driving", 64'(active), 64'(4'b0001));
        done_tick = 4'b0001;
        @(negedge clk);
        done_tick = '0;
        check_output("t5_no_timeout_tick", 64'(timeout_tick), 64'(0));
        check_output("t5_n_en_off",        64'(n_en),         64'(0));
`ifdef LED_BANK_SCHED_STATS_EN
        check_output("t5_timeout_count", 64'(timeout_count), 64'(0));
`endif
        wait_switch(10, ok);
        check_output("t5_next_switch", 64'(ok),       64'(1));
        check_output("t5_next_bank",   64'(bank_idx), 64'(1));

        // Reset while bank 1 is driving.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("t6_n_en",         64'(n_en),         64'(0));
        check_output("t6_m_en",         64'(m_en),         64'(0));
        check_output("t6_active",       64'(active),       64'(0));
        check_output("t6_switch_tick",  64'(switch_tick),  64'(0));
        check_output("t6_timeout_tick", 64'(timeout_tick), 64'(0));
        check_output("t6_bank_idx",     64'(bank_idx),     64'(3));
        reset = 1'b0;
        wait_switch(10, ok);
        check_output("t6_regrant",      64'(ok),       64'(1));
        check_output("t6_regrant_bank", 64'(bank_idx), 64'(0));
        check_output("t6_regrant_n_en", 64'(n_en),     64'(10'h155));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
